// File: rtl/dx_hazard_ctrl.sv
// Hazard controller for a five-stage in-order pipeline.
// Decides stalls, bubbles and flushes from the current pipeline contents
// and the FSM state, selects operand forwarding sources, and keeps two
// saturating performance counters.
module dx_hazard_ctrl #(
    parameter int RegAddrWidth = 4,
    parameter int FlushCycles  = 2,
    parameter int CntWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    d_valid_i,
    input  logic [RegAddrWidth-1:0] d_rs1_i,
    input  logic [RegAddrWidth-1:0] d_rs2_i,
    input  logic                    x_valid_i,
    input  logic [RegAddrWidth-1:0] x_rd_i,
    input  logic [RegAddrWidth-1:0] x_rs1_i,
    input  logic [RegAddrWidth-1:0] x_rs2_i,
    input  logic                    x_memread_i,
    input  logic                    m_valid_i,
    input  logic [RegAddrWidth-1:0] m_rd_i,
    input  logic                    m_regwrite_i,
    input  logic                    w_valid_i,
    input  logic [RegAddrWidth-1:0] w_rd_i,
    input  logic                    w_regwrite_i,
    input  logic                    branch_taken_i,
    input  logic                    mem_busy_i,
    output logic                    stall_f_o,
    output logic                    stall_d_o,
    output logic                    stall_x_o,
    output logic                    bubble_dx_o,
    output logic                    flush_fd_o,
    output logic                    flush_dx_o,
    output logic [1:0]              fwd_a_o,
    output logic [1:0]              fwd_b_o,
    output logic [1:0]              state_o,
    output logic [CntWidth-1:0]     stall_cnt_o,
    output logic [CntWidth-1:0]     flush_cnt_o
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StFlush   = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;

    // A branch holds the flush for FlushCycles cycles: the branch cycle
    // itself plus FlushReload further cycles spent in FLUSH.
    localparam logic [2:0] FlushReload = 3'(FlushCycles - 1);
    localparam bit         MultiFlush  = (FlushCycles > 1);

    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b01;

    logic [1:0]          state_q, state_d;
    logic [2:0]          fcnt_q, fcnt_d;
    logic                pending_q, pending_d;
    logic [CntWidth-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use;
    logic take_branch;
    logic in_flush;
    logic stall_f, stall_d, stall_x, bubble, flush;

    // Saturating increment: all-ones is sticky so the counters never wrap.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    // Operand source for one execute-stage register: M beats W beats regfile.
    function automatic logic [1:0] fwd_sel(
        input logic [RegAddrWidth-1:0] src,
        input logic                    m_wr,
        input logic [RegAddrWidth-1:0] m_rd,
        input logic                    w_wr,
        input logic [RegAddrWidth-1:0] w_rd
    );
        if (m_wr && (m_rd != '0) && (m_rd == src)) begin
            return FwdMem;
        end else if (w_wr && (w_rd != '0) && (w_rd == src)) begin
            return FwdWb;
        end
        return FwdReg;
    endfunction

    assign load_use = d_valid_i & x_valid_i & x_memread_i & (x_rd_i != '0) &
                      ((x_rd_i == d_rs1_i) | (x_rd_i == d_rs2_i));

    // A branch seen while memory was busy is replayed on the first free cycle.
    assign take_branch = branch_taken_i | ((state_q == StMemWait) & pending_q);

    // Leaving MEM_WAIT with a frozen non-zero flush count means the wait
    // interrupted a flush; that cycle carries on as a FLUSH cycle.
    assign in_flush = (state_q == StFlush) | ((state_q == StMemWait) & (fcnt_q != 3'd0));

    // Event arbitration and next-state: mem_busy > branch > load-use.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pending_d = pending_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_x   = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (mem_busy_i) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_x = 1'b1;
            state_d = StMemWait;
            if (branch_taken_i) begin
                pending_d = 1'b1;
            end
        end else if (take_branch) begin
            flush     = 1'b1;
            pending_d = 1'b0;
            if (MultiFlush) begin
                state_d = StFlush;
                fcnt_d  = FlushReload;
            end else begin
                state_d = StRun;
                fcnt_d  = 3'd0;
            end
        end else if (in_flush) begin
            flush = 1'b1;
            if (fcnt_q <= 3'd1) begin
                state_d = StRun;
                fcnt_d  = 3'd0;
            end else begin
                state_d = StFlush;
                fcnt_d  = fcnt_q - 3'd1;
            end
        end else begin
            state_d = StRun;
            if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                bubble  = 1'b1;
            end
        end
    end

    // Control outputs are forced low while reset is asserted.
    assign stall_f_o   = stall_f & reset_ni;
    assign stall_d_o   = stall_d & reset_ni;
    assign stall_x_o   = stall_x & reset_ni;
    assign bubble_dx_o = bubble & reset_ni;
    assign flush_fd_o  = flush & reset_ni;
    assign flush_dx_o  = flush & reset_ni;

    assign fwd_a_o = fwd_sel(x_rs1_i, m_valid_i & m_regwrite_i, m_rd_i,
                             w_valid_i & w_regwrite_i, w_rd_i);
    assign fwd_b_o = fwd_sel(x_rs2_i, m_valid_i & m_regwrite_i, m_rd_i,
                             w_valid_i & w_regwrite_i, w_rd_i);

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // FSM state, flush countdown and deferred-branch flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StRun;
            fcnt_q    <= 3'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pending_q <= pending_d;
        end
    end

    // Performance counters: stall cycles and flush cycles, saturating.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f_o) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush_dx_o) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

endmodule

// File: tb/tb_dx_hazard_ctrl.sv
// Directed bench for dx_hazard_ctrl. A second instance with a 2-bit counter
// width exercises counter saturation.
module tb_dx_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic       d_valid, x_valid, x_memread, m_valid, m_regwrite;
    logic       w_valid, w_regwrite, branch, busy;
    logic [3:0] d_rs1, d_rs2, x_rd, x_rs1, x_rs2, m_rd, w_rd;

    logic        stall_f, stall_d, stall_x, bubble, flush_fd, flush_dx;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_f, s_stall_d, s_stall_x, s_bubble, s_flush_fd, s_flush_dx;
    logic [1:0]  s_fwd_a, s_fwd_b, s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ctl;
    assign ctl = {stall_f, stall_d, stall_x, bubble, flush_fd, flush_dx, state};

    always #5 clk = ~clk;

    dx_hazard_ctrl #(.RegAddrWidth(4), .FlushCycles(2), .CntWidth(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .d_valid_i(d_valid), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
        .x_valid_i(x_valid), .x_rd_i(x_rd), .x_rs1_i(x_rs1), .x_rs2_i(x_rs2),
        .x_memread_i(x_memread),
        .m_valid_i(m_valid), .m_rd_i(m_rd), .m_regwrite_i(m_regwrite),
        .w_valid_i(w_valid), .w_rd_i(w_rd), .w_regwrite_i(w_regwrite),
        .branch_taken_i(branch), .mem_busy_i(busy),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_x_o(stall_x),
        .bubble_dx_o(bubble), .flush_fd_o(flush_fd), .flush_dx_o(flush_dx),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    dx_hazard_ctrl #(.RegAddrWidth(4), .FlushCycles(2), .CntWidth(2)) dut_sat (
        .clk_i(clk), .reset_ni(reset_ni),
        .d_valid_i(d_valid), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
        .x_valid_i(x_valid), .x_rd_i(x_rd), .x_rs1_i(x_rs1), .x_rs2_i(x_rs2),
        .x_memread_i(x_memread),
        .m_valid_i(m_valid), .m_rd_i(m_rd), .m_regwrite_i(m_regwrite),
        .w_valid_i(w_valid), .w_rd_i(w_rd), .w_regwrite_i(w_regwrite),
        .branch_taken_i(branch), .mem_busy_i(busy),
        .stall_f_o(s_stall_f), .stall_d_o(s_stall_d), .stall_x_o(s_stall_x),
        .bubble_dx_o(s_bubble), .flush_fd_o(s_flush_fd), .flush_dx_o(s_flush_dx),
        .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b), .state_o(s_state),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    task automatic idle();
        d_valid = 0; d_rs1 = 0; d_rs2 = 0;
        x_valid = 0; x_rd = 0; x_rs1 = 0; x_rs2 = 0; x_memread = 0;
        m_valid = 0; m_rd = 0; m_regwrite = 0;
        w_valid = 0; w_rd = 0; w_regwrite = 0;
        branch = 0; busy = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_ni = 0;
        busy = 1; branch = 1;
        x_rs1 = 5; m_valid = 1; m_rd = 5; m_regwrite = 1;
        #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rst_ctl got %b want %b", ctl, 8'h00); end
        n_cmp++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL rst_fwd_a got %b want 10", fwd_a); end
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rst_ctl_held got %b want %b", ctl, 8'h00); end
        n_cmp++; if ({stall_cnt, flush_cnt} !== 32'h0) begin n_err++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        idle();
        reset_ni = 1;
    endtask

    task automatic test_load_use();
        @(negedge clk); idle();
        d_valid = 1; d_rs1 = 3; x_valid = 1; x_rd = 3; x_memread = 1; #1;
        n_cmp++; if (ctl !== 8'b11010000) begin n_err++; $display("FAIL lu_rs1 got %b want %b", ctl, 8'b11010000); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL lu_after got %b want %b", ctl, 8'h00); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt1 got %0d want 1", stall_cnt); end
        @(negedge clk);
        d_valid = 1; d_rs1 = 0; x_valid = 1; x_rd = 0; x_memread = 1; #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL lu_rd0 got %b want %b", ctl, 8'h00); end
        @(negedge clk);
        d_rs1 = 1; d_rs2 = 7; x_rd = 7; #1;
        n_cmp++; if (ctl !== 8'b11010000) begin n_err++; $display("FAIL lu_rs2 got %b want %b", ctl, 8'b11010000); end
        @(negedge clk);
        x_memread = 0; #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL lu_nomem got %b want %b", ctl, 8'h00); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL lu_cnt2 got %0d want 2", stall_cnt); end
    endtask

    task automatic test_forward();
        idle();
        x_rs1 = 5; x_rs2 = 0;
        m_valid = 1; m_rd = 5; m_regwrite = 1;
        w_valid = 1; w_rd = 5; w_regwrite = 1; #1;
        n_cmp++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_m_wins got %b want 10", fwd_a); end
        n_cmp++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_x0 got %b want 00", fwd_b); end
        m_rd = 0; #1;
        n_cmp++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_w got %b want 01", fwd_a); end
        x_rs2 = 5; m_rd = 5; m_regwrite = 0; #1;
        n_cmp++; if (fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_b_nowr got %b want 01", fwd_b); end
        w_regwrite = 0; #1;
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL fwd_none got %b want 0000", {fwd_a, fwd_b}); end
        idle();
    endtask

    task automatic test_branch();
        @(negedge clk); idle(); branch = 1; #1;
        n_cmp++; if (ctl !== 8'b00001100) begin n_err++; $display("FAIL br_c1 got %b want %b", ctl, 8'b00001100); end
        @(negedge clk); branch = 0; #1;
        n_cmp++; if (ctl !== 8'b00001101) begin n_err++; $display("FAIL br_c2 got %b want %b", ctl, 8'b00001101); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL br_c3 got %b want %b", ctl, 8'h00); end
        n_cmp++; if (flush_cnt !== 16'd2) begin n_err++; $display("FAIL br_cnt got %0d want 2", flush_cnt); end
    endtask

    task automatic test_priority();
        @(negedge clk); idle();
        d_valid = 1; d_rs1 = 3; x_valid = 1; x_rd = 3; x_memread = 1; branch = 1; #1;
        n_cmp++; if (ctl !== 8'b00001100) begin n_err++; $display("FAIL pri_c1 got %b want %b", ctl, 8'b00001100); end
        @(negedge clk); idle(); #1;
        n_cmp++; if (ctl !== 8'b00001101) begin n_err++; $display("FAIL pri_c2 got %b want %b", ctl, 8'b00001101); end
        @(negedge clk); #1;
        n_cmp++; if (flush_cnt !== 16'd4) begin n_err++; $display("FAIL pri_cnt got %0d want 4", flush_cnt); end
    endtask

    task automatic test_mem_wait();
        @(negedge clk); idle(); busy = 1; #1;
        n_cmp++; if (ctl !== 8'b11100000) begin n_err++; $display("FAIL mw_c1 got %b want %b", ctl, 8'b11100000); end
        @(negedge clk); branch = 1; #1;
        n_cmp++; if (ctl !== 8'b11100010) begin n_err++; $display("FAIL mw_c2 got %b want %b", ctl, 8'b11100010); end
        @(negedge clk); branch = 0; #1;
        n_cmp++; if (ctl !== 8'b11100010) begin n_err++; $display("FAIL mw_c3 got %b want %b", ctl, 8'b11100010); end
        @(negedge clk); busy = 0; #1;
        n_cmp++; if (ctl !== 8'b00001110) begin n_err++; $display("FAIL mw_c4 got %b want %b", ctl, 8'b00001110); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'b00001101) begin n_err++; $display("FAIL mw_c5 got %b want %b", ctl, 8'b00001101); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL mw_c6 got %b want %b", ctl, 8'h00); end
        n_cmp++; if ({stall_cnt, flush_cnt} !== {16'd5, 16'd6}) begin n_err++;
            $display("FAIL mw_cnt got %0d/%0d want 5/6", stall_cnt, flush_cnt); end
    endtask

    task automatic test_flush_resume();
        @(negedge clk); idle(); branch = 1; #1;
        n_cmp++; if (ctl !== 8'b00001100) begin n_err++; $display("FAIL fr_c1 got %b want %b", ctl, 8'b00001100); end
        @(negedge clk); branch = 0; busy = 1; #1;
        n_cmp++; if (ctl !== 8'b11100001) begin n_err++; $display("FAIL fr_c2 got %b want %b", ctl, 8'b11100001); end
        @(negedge clk); busy = 0; #1;
        n_cmp++; if (ctl !== 8'b00001110) begin n_err++; $display("FAIL fr_c3 got %b want %b", ctl, 8'b00001110); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL fr_c4 got %b want %b", ctl, 8'h00); end
        n_cmp++; if ({stall_cnt, flush_cnt} !== {16'd6, 16'd8}) begin n_err++;
            $display("FAIL fr_cnt got %0d/%0d want 6/8", stall_cnt, flush_cnt); end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk); idle(); branch = 1;
        @(negedge clk); branch = 0; #1;
        n_cmp++; if (ctl !== 8'b00001101) begin n_err++; $display("FAIL rmf_pre got %b want %b", ctl, 8'b00001101); end
        #1 reset_ni = 0;
        #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rmf_ctl got %b want %b", ctl, 8'h00); end
        n_cmp++; if ({stall_cnt, flush_cnt} !== 32'h0) begin n_err++;
            $display("FAIL rmf_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk); reset_ni = 1;
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rmf_after got %b want %b", ctl, 8'h00); end
    endtask

    task automatic test_saturate();
        @(negedge clk); idle(); busy = 1;
        @(negedge clk);
        @(negedge clk); busy = 0; #1;
        n_cmp++; if (s_stall_cnt !== 2'd2) begin n_err++; $display("FAIL sat_pre got %0d want 2", s_stall_cnt); end
        busy = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); busy = 0; #1;
        n_cmp++; if (s_stall_cnt !== 2'd3) begin n_err++; $display("FAIL sat_hold got %0d want 3", s_stall_cnt); end
        n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide got %0d want 5", stall_cnt); end
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_priority();
        test_mem_wait();
        test_flush_resume();
        test_reset_mid_flush();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
